// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES request arbiter.
// Contents:
//   arb_state_e   - arbiter FSM state encoding
//   AES_KEY_LEN   - default cipher key width
//   AES_DATA_LEN  - default block width
//   clog2()       - ceiling log2, usable in constant expressions
package aes_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int AES_KEY_LEN  = 128;
  localparam int AES_DATA_LEN = 128;

  // Smallest n with 2**n >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection.
// Ports:
//   req     in  NUM_REQ          request vector
//   ptr     in  clog2(NUM_REQ)   highest-priority index this cycle
//   enable  in  1                when low, no grant is produced
//   grant   out NUM_REQ          one-hot grant (all zero if none)
// The pointer register lives in the parent.
module rr_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] ptr,
  input  logic                      enable,
  output logic [NUM_REQ-1:0]        grant
);

  localparam int IDX_W = clog2(NUM_REQ);

  always_comb begin
    int               pos;
    logic             found;
    logic [IDX_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    // Walk from ptr upward with wraparound; the first set request wins.
    for (int off = 0; off < NUM_REQ; off++) begin
      pos = int'(ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = IDX_W'(pos);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin scheduler sharing one AES-128 core among NUM_REQ requesters.
// One request is in flight at a time: IDLE grants, ISSUE pulses the core,
// WAIT holds the operands until the core answers, RESP offers the result
// to the winning requester until it accepts.
// Optional feature macro: AES_ARB_TIMEOUT_EN adds a WAIT watchdog that
// flushes the core and returns an error response after TIMEOUT_CYCLES.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot)
//   req_plain_text/key      packed operands, requester i at [i*W +: W]
//   resp_valid/resp_ready   per-requester response handshake (valid one-hot)
//   resp_cipher_text        shared response data, persists after handshake
//   resp_error              response is a timeout (data is zero)
//   core_*                  AES core issue/result interface
//   core_flush              one-cycle pulse, ORed into the core reset
//   busy                    high whenever the FSM is not IDLE
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int KEY_LEN        = AES_KEY_LEN,
  parameter int DATA_LEN       = AES_DATA_LEN,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_plain_text,
  input  logic [NUM_REQ*KEY_LEN-1:0]  req_cipher_key,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [DATA_LEN-1:0]         resp_cipher_text,
  output logic                        resp_error,
  output logic                        core_data_valid_in,
  output logic                        core_key_valid_in,
  output logic [DATA_LEN-1:0]         core_plain_text,
  output logic [KEY_LEN-1:0]          core_cipher_key,
  input  logic                        core_data_valid_out,
  input  logic [DATA_LEN-1:0]         core_cipher_text,
  output logic                        core_flush,
  output logic                        busy
);

  localparam int IDX_W = clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic [DATA_LEN-1:0] pt_q, pt_d;
  logic [KEY_LEN-1:0]  key_q, key_d;
  logic [DATA_LEN-1:0] resp_data_q, resp_data_d;
  logic                resp_error_q, resp_error_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .enable (state_q == IDLE),
    .grant  (grant)
  );

  // The arbiter only grants asserted requests, so any grant is an accept.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Cleared in ISSUE so every WAIT starts counting from zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT && !timeout_hit) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  // A core result arriving in the expiry cycle takes precedence.
  assign timeout_hit = (state_q == WAIT) && !core_data_valid_out &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_idx_d    = cur_idx_q;
    pt_d         = pt_q;
    key_d        = key_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          pt_d      = req_plain_text[grant_idx*DATA_LEN +: DATA_LEN];
          key_d     = req_cipher_key[grant_idx*KEY_LEN +: KEY_LEN];
          cur_idx_d = grant_idx;
          rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_data_valid_out) begin
          resp_data_d  = core_cipher_text;
          resp_error_d = 1'b0;
          state_d      = RESP;
        end else if (timeout_hit) begin
          resp_data_d  = '0;
          resp_error_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        // Only the owner of the pending response can complete it.
        if (resp_ready[cur_idx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cur_idx_q    <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_idx_q    <= cur_idx_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == RESP) resp_valid[cur_idx_q] = 1'b1;
  end

  assign req_ready          = grant;
  assign resp_cipher_text   = resp_data_q;
  assign resp_error         = resp_error_q;
  assign core_data_valid_in = (state_q == ISSUE);
  assign core_key_valid_in  = (state_q == ISSUE);
  assign core_plain_text    = pt_q;
  assign core_cipher_key    = key_q;
  assign core_flush         = timeout_hit;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter with a stand-in AES core that
// answers a fixed number of cycles after each issue pulse. The known
// FIPS-197 vector maps to its published ciphertext; other operands map to
// a simple keyed mix so each requester's result is distinguishable.
module tb_aes_req_arbiter;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [511:0] req_plain_text;
  logic [511:0] req_cipher_key;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [127:0] resp_cipher_text;
  logic         resp_error;
  logic         core_data_valid_in;
  logic         core_key_valid_in;
  logic [127:0] core_plain_text;
  logic [127:0] core_cipher_key;
  logic         core_data_valid_out;
  logic [127:0] core_cipher_text;
  logic         core_flush;
  logic         busy;

  logic         model_dvo;
  logic [127:0] model_ct;
  logic         inject_dvo;
  logic [127:0] inject_ct;
  logic         core_mute;
  int           core_lat;

  logic [127:0] pt_arr [4];
  logic [127:0] key_arr[4];

  int n_checks;
  int n_fail;

  assign core_data_valid_out = model_dvo | inject_dvo;
  assign core_cipher_text    = inject_dvo ? inject_ct : model_ct;

  aes_req_arbiter #(
    .NUM_REQ        (4),
    .KEY_LEN        (128),
    .DATA_LEN       (128),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_plain_text      (req_plain_text),
    .req_cipher_key      (req_cipher_key),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_cipher_text    (resp_cipher_text),
    .resp_error          (resp_error),
    .core_data_valid_in  (core_data_valid_in),
    .core_key_valid_in   (core_key_valid_in),
    .core_plain_text     (core_plain_text),
    .core_cipher_key     (core_cipher_key),
    .core_data_valid_out (core_data_valid_out),
    .core_cipher_text    (core_cipher_text),
    .core_flush          (core_flush),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_c3c3_f0f0_1234_5678;
  endfunction

  function automatic int oh2idx(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Stand-in core: issue seen in cycle X -> result valid in cycle X+core_lat.
  initial begin : core_model
    int           cnt;
    logic [127:0] pend_pt;
    logic [127:0] pend_key;
    cnt       = 0;
    pend_pt   = '0;
    pend_key  = '0;
    model_dvo = 1'b0;
    model_ct  = '0;
    forever begin
      @(negedge clk);
      if (core_data_valid_in) begin
        check("key_pulse", {127'd0, core_key_valid_in}, 128'd1);
        if (!core_mute) begin
          pend_pt  = core_plain_text;
          pend_key = core_cipher_key;
          cnt      = core_lat;
        end
      end
      @(posedge clk);
      #1;
      model_dvo = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_dvo = 1'b1;
          model_ct  = core_fn(pend_pt, pend_key);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Bounded wait for a grant (on_resp=0) or a response (on_resp=1).
  task automatic wait_for(input bit on_resp, input string name);
    int  t;
    bit  seen;
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 100) begin
      @(negedge clk);
      t++;
      seen = on_resp ? (|resp_valid) : (|req_ready);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles, required event never seen", name, t);
    end
  endtask

  // One full transaction at nominal core latency with exact cycle checks.
  task automatic run_txn(input logic [3:0] rv, input logic [3:0] exp_g);
    int idx;
    idx = oh2idx(exp_g);
    @(posedge clk);
    #1;
    req_valid = rv;
    @(negedge clk);                                   // cycle A
    check("txn_grant", {124'd0, req_ready}, {124'd0, exp_g});
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);                                   // A+1
    check("txn_issue", {127'd0, core_data_valid_in}, 128'd1);
    check("txn_core_pt", core_plain_text, pt_arr[idx]);
    check("txn_core_key", core_cipher_key, key_arr[idx]);
    @(negedge clk);                                   // A+2
    check("txn_issue_end", {127'd0, core_data_valid_in}, 128'd0);
    repeat (10) @(negedge clk);                       // A+12
    check("txn_resp_early", {124'd0, resp_valid}, 128'd0);
    @(negedge clk);                                   // A+13
    check("txn_resp_valid", {124'd0, resp_valid}, {124'd0, exp_g});
    check("txn_resp_data", resp_cipher_text, core_fn(pt_arr[idx], key_arr[idx]));
    check("txn_resp_err", {127'd0, resp_error}, 128'd0);
    @(negedge clk);                                   // A+14
    check("txn_idle", {127'd0, busy}, 128'd0);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    logic [3:0]   e;
    logic [127:0] exp_data;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 4'hF;
    inject_dvo = 1'b0;
    inject_ct  = '0;
    core_mute  = 1'b0;
    core_lat   = 11;

    pt_arr[0]  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    key_arr[0] = 128'h1111222233334444555566667777888a;
    pt_arr[1]  = 128'hdeadbeef0123456789abcdeffedcba98;
    key_arr[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pt_arr[2]  = FIPS_PT;
    key_arr[2] = FIPS_KEY;
    pt_arr[3]  = 128'h3243f6a8885a308d313198a2e0370734;
    key_arr[3] = 128'hfedcba9876543210f0e1d2c3b4a59687;
    req_plain_text = {pt_arr[3], pt_arr[2], pt_arr[1], pt_arr[0]};
    req_cipher_key = {key_arr[3], key_arr[2], key_arr[1], key_arr[0]};

    // rr_ptr after each entry: 3,1,2,0,0,2,3
    vecs[0] = '{req: 4'b0100, exp_grant: 4'b0100};
    vecs[1] = '{req: 4'b0011, exp_grant: 4'b0001};
    vecs[2] = '{req: 4'b0011, exp_grant: 4'b0010};
    vecs[3] = '{req: 4'b1001, exp_grant: 4'b1000};
    vecs[4] = '{req: 4'b1000, exp_grant: 4'b1000};
    vecs[5] = '{req: 4'b0110, exp_grant: 4'b0010};
    vecs[6] = '{req: 4'b1111, exp_grant: 4'b0100};

    // Reset state
    reset_dut();
    @(negedge clk);
    check("rst_req_ready", {124'd0, req_ready}, 128'd0);
    check("rst_resp_valid", {124'd0, resp_valid}, 128'd0);
    check("rst_resp_data", resp_cipher_text, 128'd0);
    check("rst_resp_err", {127'd0, resp_error}, 128'd0);
    check("rst_core_dv", {127'd0, core_data_valid_in}, 128'd0);
    check("rst_core_kv", {127'd0, core_key_valid_in}, 128'd0);
    check("rst_core_pt", core_plain_text, 128'd0);
    check("rst_core_key", core_cipher_key, 128'd0);
    check("rst_flush", {127'd0, core_flush}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);

    // Table-driven transactions (first entry is the FIPS single request)
    for (int v = 0; v < 7; v++) run_txn(vecs[v].req, vecs[v].exp_grant);

    // Core result outside WAIT is ignored; last response data persists.
    @(posedge clk);
    #1;
    inject_ct  = 128'hdead_0000_beef_0000_cafe_0000_f00d_0000;
    inject_dvo = 1'b1;
    @(posedge clk);
    #1;
    inject_dvo = 1'b0;
    @(negedge clk);
    check("stray_busy", {127'd0, busy}, 128'd0);
    check("stray_data", resp_cipher_text, FIPS_CT);

    // Fairness: everyone valid, responses accepted immediately
    reset_dut();
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      e = 4'b0001 << (k % 4);
      wait_for(1'b0, "fair_grant_wait");
      check("fair_grant", {124'd0, req_ready}, {124'd0, e});
      wait_for(1'b1, "fair_resp_wait");
      check("fair_resp", {124'd0, resp_valid}, {124'd0, e});
      check("fair_data", resp_cipher_text, core_fn(pt_arr[k % 4], key_arr[k % 4]));
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (14) @(negedge clk);

    // Backpressure on requester 1 while requester 3 waits
    reset_dut();
    resp_ready = 4'b1101;
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("bp_grant", {124'd0, req_ready}, 128'h2);
    exp_data = core_fn(pt_arr[1], key_arr[1]);
    wait_for(1'b1, "bp_resp_wait");
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      check("bp_valid", {124'd0, resp_valid}, 128'h2);
      check("bp_data", resp_cipher_text, exp_data);
      check("bp_nogrant", {124'd0, req_ready}, 128'd0);
      check("bp_noissue", {127'd0, core_data_valid_in}, 128'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 4'hF;
    @(negedge clk);
    check("bp_hs_valid", {124'd0, resp_valid}, 128'h2);
    @(negedge clk);
    check("bp_regrant", {124'd0, req_ready}, 128'h8);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_for(1'b1, "bp_resp3_wait");
    check("bp_resp3", {124'd0, resp_valid}, 128'h8);
    check("bp_data3", resp_cipher_text, core_fn(pt_arr[3], key_arr[3]));
    repeat (2) @(negedge clk);

    // Reset while in WAIT
    reset_dut();
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    @(negedge clk);                                   // A
    check("rw_grant", {124'd0, req_ready}, 128'h1);
    @(posedge clk);
    #1;
    req_valid = '0;                                   // A+1
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;                                     // A+5
    @(posedge clk);
    #1;
    reset = 1'b0;                                     // A+6
    @(negedge clk);
    check("rw_busy", {127'd0, busy}, 128'd0);
    check("rw_resp_valid", {124'd0, resp_valid}, 128'd0);
    check("rw_core_pt", core_plain_text, 128'd0);
    check("rw_core_key", core_cipher_key, 128'd0);
    check("rw_resp_data", resp_cipher_text, 128'd0);
    check("rw_flush", {127'd0, core_flush}, 128'd0);
    repeat (6) @(negedge clk);                        // A+12, late core result
    check("rw_late_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);                                   // A+13
    check("rw_late_resp", {124'd0, resp_valid}, 128'd0);
    check("rw_late_data", resp_cipher_text, 128'd0);
    run_txn(4'b0011, 4'b0001);                        // ptr restarted at 0

`ifdef AES_ARB_TIMEOUT_EN
    // Watchdog expiry with a silent core
    reset_dut();
    run_txn(4'b0001, 4'b0001);
    core_mute = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    @(negedge clk);                                   // A
    check("to_grant", {124'd0, req_ready}, 128'h2);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (8) @(negedge clk);                        // A+8
    check("to_flush_early", {127'd0, core_flush}, 128'd0);
    @(negedge clk);                                   // A+9
    check("to_flush", {127'd0, core_flush}, 128'd1);
    @(negedge clk);                                   // A+10
    check("to_resp_valid", {124'd0, resp_valid}, 128'h2);
    check("to_resp_err", {127'd0, resp_error}, 128'd1);
    check("to_resp_data", resp_cipher_text, 128'd0);
    check("to_flush_end", {127'd0, core_flush}, 128'd0);
    @(negedge clk);
    check("to_idle", {127'd0, busy}, 128'd0);

    // Core answers in the expiry cycle
    core_mute = 1'b0;
    core_lat  = 8;
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    @(negedge clk);
    check("col_grant", {124'd0, req_ready}, 128'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (8) @(negedge clk);                        // A+8
    @(negedge clk);                                   // A+9
    check("col_flush", {127'd0, core_flush}, 128'd0);
    @(negedge clk);                                   // A+10
    check("col_resp_valid", {124'd0, resp_valid}, 128'h4);
    check("col_resp_err", {127'd0, resp_error}, 128'd0);
    check("col_resp_data", resp_cipher_text, FIPS_CT);
    core_lat = 11;
    repeat (2) @(negedge clk);
`else
    // Without the watchdog a silent core keeps the arbiter busy.
    reset_dut();
    core_mute = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (100) @(negedge clk);
    check("nto_busy", {127'd0, busy}, 128'd1);
    check("nto_resp_valid", {124'd0, resp_valid}, 128'd0);
    check("nto_flush", {127'd0, core_flush}, 128'd0);
    core_mute = 1'b0;
    reset_dut();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
